// File: rtl/led_count_scheduler.sv
// ---------------------------------------------------------------------------
// led_count_scheduler
//   Shares one LED counting datapath between two requesters. Requests are
//   arbitrated round-robin. The owner's run counts 0..MAX_COUNT, advancing on
//   a slow tick divided down from clk30, and ends with a one-cycle done pulse
//   on the owner's bit. Dropping the owner's request mid-run aborts the run.
//
//   Optional feature macro: SCHED_PAUSE_EN (adds the pause input).
//
// Ports
//   clk30  in   system clock
//   rst_n  in   asynchronous active-low reset
//   req    in   [1:0] level requests, debounced, synchronous to clk30
//   grant  out  [1:0] one-hot datapath owner, 0 when idle
//   count  out  [COUNT_W-1:0] current count value
//   tick   out  one-cycle strobe in the last prescaler cycle of each tick
//   busy   out  high whenever the controller is not idle
//   done   out  [1:0] one-cycle pulse on the owner's bit at run completion
//   pause  in   (SCHED_PAUSE_EN only) freezes an active run while high
// ---------------------------------------------------------------------------
module led_count_scheduler #(
  parameter int CLK_HZ    = 30000000,
  parameter int TICK_HZ   = 4,
  parameter int COUNT_W   = 4,
  parameter int MAX_COUNT = 15
) (
  input  logic               clk30,
  input  logic               rst_n,
  input  logic [1:0]         req,
  output logic [1:0]         grant,
  output logic [COUNT_W-1:0] count,
  output logic               tick,
  output logic               busy,
  output logic [1:0]         done
`ifdef SCHED_PAUSE_EN
  ,
  input  logic               pause
`endif
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PRESC_W  = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [COUNT_W-1:0] COUNT_LAST = COUNT_W'(MAX_COUNT);

  // Plain 2-bit codes so the unused encoding is representable and recoverable.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         r_state, w_state_nxt;
  logic [1:0]         r_grant, w_grant_nxt;
  logic [COUNT_W-1:0] r_count, w_count_nxt;
  logic [PRESC_W-1:0] r_presc, w_presc_nxt;
  logic               r_prio,  w_prio_nxt;
  logic               r_tick,  w_tick_nxt;
  logic [1:0]         r_done,  w_done_nxt;
  logic [1:0]         w_arb;
  logic               w_pause;
  logic               w_abort;
  logic               w_wrap;

`ifdef SCHED_PAUSE_EN
  assign w_pause = pause;
`else
  assign w_pause = 1'b0;
`endif

  // Owner lost its request; the other requester's level is ignored in RUN.
  assign w_abort = ((req & r_grant) == 2'b00);
  // Prescaler expiry that actually advances the run (frozen while paused).
  assign w_wrap  = (r_presc == PRESC_LAST) && !w_pause;

  // Round-robin pick; r_prio names the requester favoured on contention.
  always_comb begin
    case (req)
      2'b01:   w_arb = 2'b01;
      2'b10:   w_arb = 2'b10;
      2'b11:   w_arb = r_prio ? 2'b10 : 2'b01;
      default: w_arb = 2'b00;
    endcase
  end

  // State register
  always_ff @(posedge clk30 or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_nxt = (req != 2'b00) ? ST_RUN : ST_IDLE;
      ST_RUN: begin
        if (w_abort)                               w_state_nxt = ST_IDLE;
        else if (w_wrap && (r_count == COUNT_LAST)) w_state_nxt = ST_DONE;
        else                                       w_state_nxt = ST_RUN;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and datapath
  always_comb begin
    w_grant_nxt = r_grant;
    w_count_nxt = r_count;
    w_presc_nxt = r_presc;
    w_prio_nxt  = r_prio;
    w_done_nxt  = 2'b00;
    case (r_state)
      ST_IDLE: begin
        w_grant_nxt = w_arb;
        w_count_nxt = '0;
        w_presc_nxt = '0;
      end
      ST_RUN: begin
        if (w_abort) begin
          w_grant_nxt = 2'b00;
          w_count_nxt = '0;
          w_presc_nxt = '0;
          w_prio_nxt  = ~r_grant[1];
        end else if (w_pause) begin
          w_presc_nxt = r_presc;
        end else if (w_wrap) begin
          w_presc_nxt = '0;
          if (r_count == COUNT_LAST) w_done_nxt  = r_grant;
          else                       w_count_nxt = r_count + COUNT_W'(1);
        end else begin
          w_presc_nxt = r_presc + PRESC_W'(1);
        end
      end
      ST_DONE: begin
        w_grant_nxt = 2'b00;
        w_count_nxt = '0;
        w_presc_nxt = '0;
        w_prio_nxt  = ~r_grant[1];
      end
      default: begin
        w_grant_nxt = 2'b00;
        w_count_nxt = '0;
        w_presc_nxt = '0;
      end
    endcase
    // tick is registered, so it is raised on the edge that loads the last
    // prescaler value; a frozen prescaler never shows a tick.
    w_tick_nxt = (w_state_nxt == ST_RUN) && (w_presc_nxt == PRESC_LAST) && !w_pause;
  end

  // Registered outputs and datapath
  always_ff @(posedge clk30 or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= 2'b00;
      r_count <= '0;
      r_presc <= '0;
      r_prio  <= 1'b0;
      r_tick  <= 1'b0;
      r_done  <= 2'b00;
    end else begin
      r_grant <= w_grant_nxt;
      r_count <= w_count_nxt;
      r_presc <= w_presc_nxt;
      r_prio  <= w_prio_nxt;
      r_tick  <= w_tick_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign grant = r_grant;
  assign count = r_count;
  assign tick  = r_tick;
  assign done  = r_done;
  assign busy  = (r_state != ST_IDLE);

endmodule

// File: doc/led_count_scheduler.md
Name: led_count_scheduler

Overview:
- Controller that shares one LED counting datapath between two requesters, e.g. two debounced button "go" lines or two software agents.
- Round-robin arbitration between the requesters.
- Generates the slow count tick internally from the board clock.
- Sequences each granted run from 0 to MAX_COUNT and reports completion per requester.
- Sits between the button-conditioning logic and the LED output mux in the top level.

Parameters:
- CLK_HZ, 30000000, input clock frequency in Hz.
- TICK_HZ, 4, count-tick rate in Hz. TICK_DIV = CLK_HZ/TICK_HZ (integer divide); must be >= 2.
- COUNT_W, 4, width of the count output.
- MAX_COUNT, 15, terminal count value; must be < 2^COUNT_W.

Ports:
- clk30  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  level requests, active-high, synchronous to clk30, already debounced.
- grant  out  2  one-hot owner of the datapath, 0 when idle.
- count  out  COUNT_W  current count value, driven to the LEDs by the top level.
- tick  out  1  one-cycle strobe each time the prescaler expires in RUN.
- busy  out  1  high whenever state != IDLE.
- done  out  2  one-cycle pulse on the bit of the requester whose run completed.

Behaviour:
- Reset:
  - Asynchronous, on rst_n low, from any state.
  - grant=0, count=0, tick=0, done=0, busy=0.
  - state=IDLE, prescaler=0, priority pointer prio=0 (req[0] favoured first).
- States: IDLE, RUN, DONE. Encodings not listed fall to IDLE on the next edge.
- IDLE:
  - count=0, grant=0.
  - If req!=0 at an edge: go to RUN, register grant, clear the prescaler.
  - Single request: that requester is granted.
  - Both requests: the requester indexed by prio is granted.
- RUN:
  - Prescaler counts 0..TICK_DIV-1; tick=1 in the cycle the prescaler equals TICK_DIV-1, then the prescaler wraps to 0.
  - On tick with count<MAX_COUNT: count+1.
  - On tick with count==MAX_COUNT: go to DONE; count holds MAX_COUNT.
  - The first increment occurs TICK_DIV cycles after the grant edge. A full run lasts (MAX_COUNT+1)*TICK_DIV cycles in RUN.
- DONE:
  - Exactly one cycle. done[owner]=1, grant still shows the owner, count=MAX_COUNT.
  - Next edge: go to IDLE, grant=0, count=0, prio = index of the other requester.
- Abort:
  - The owner's req deasserts at any edge in RUN: go to IDLE next edge.
  - No done pulse; count and prescaler cleared; prio = index of the other requester.
  - The non-owner's req is ignored while in RUN.
- Regrant latency:
  - At least one IDLE cycle separates runs. The earliest regrant is 2 edges after entering DONE.
  - A requester held high continuously is re-served only if the other requester is low at the arbitration edge.
- done, tick and grant are registered outputs, glitch-free. busy decodes state.

Optional Feature:
- Macro SCHED_PAUSE_EN.
- Defined:
  - Adds port pause (in, 1, active-high).
  - While pause=1 in RUN: prescaler, count and tick freeze (tick forced 0); grant is held; abort on req drop still applies.
  - Pause has no effect in IDLE or DONE.
- Undefined: no pause port exists; RUN always advances.

Test Plan:
All scenarios use CLK_HZ=8, TICK_HZ=2 (TICK_DIV=4), COUNT_W=4, MAX_COUNT=3.
- Single run: req=01 held from reset release.
  - grant=01 at edge 1; count=1,2,3 at edges 5,9,13; DONE at edge 17 with done=01 for one cycle; IDLE with grant=00, count=0 at edge 18.
- Contention: req=11 held.
  - First grant=01; after its DONE and one IDLE cycle, grant=10; afterwards grants alternate 01/10.
  - Check tick cadence is exactly 1 pulse per 4 cycles in RUN.
- Abort: req=10; drop req[1] 6 cycles after grant.
  - Next edge: IDLE, count=0, done=00; the next simultaneous request is granted to 01.
- Async reset mid-run: assert rst_n=0 mid-cycle with count=2.
  - Outputs go to 0 immediately without waiting for a clock edge.
  - After release with req=11, grant=01 (prio reset).
- Pause (SCHED_PAUSE_EN): pause=1 for 10 cycles at count=1.
  - count stays 1 and no tick pulses; after release the next increment comes 4-p cycles later, where p is the prescaler value at pause entry.
  - Build without the macro and confirm no pause port exists.
